regfile_writeback: RTL and testbench

- Writer-side front end for the 32-entry register file: collects results from the single-cycle ALU path and from multi-cycle units (load/mul), and drives RW/RegWrite/busW with at most one write per cycle.
- Buffers slow-unit results in a small FIFO and suppresses writes to x0.
- Keeps a pending-destination scoreboard that decode queries for RAW hazards.

---
 rtl/regfile_writeback.sv | 129 ++++++++++++
 tb/tb_regfile_writeback.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register-file write-side front end: merges ALU and slow-unit results into a
// single registered write port, buffers slow results in a small FIFO,
// drops writes to x0 and tracks outstanding destinations for decode.
module regfile_writeback #(
    parameter int WIDTH      = 32,
    parameter int REGADDR_W  = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [REGADDR_W-1:0]          alu_rd,
    input  logic [WIDTH-1:0]              alu_data,
    input  logic                          slow_valid,
    output logic                          slow_ready,
    input  logic [REGADDR_W-1:0]          slow_rd,
    input  logic [WIDTH-1:0]              slow_data,
    input  logic                          issue_valid,
    input  logic [REGADDR_W-1:0]          issue_rd,
    input  logic [REGADDR_W-1:0]          rs1,
    input  logic [REGADDR_W-1:0]          rs2,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    output logic [REGADDR_W-1:0]          RW,
    output logic                          RegWrite,
    output logic [WIDTH-1:0]              busW,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREGS = 2 ** REGADDR_W;

    logic [REGADDR_W-1:0] fifo_rd   [FIFO_DEPTH];
    logic [WIDTH-1:0]     fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    logic                 sel_vld_p0;
    logic [REGADDR_W-1:0] sel_rd_p0;
    logic [WIDTH-1:0]     sel_data_p0;

    logic [NREGS-1:0]     pending;
    logic [NREGS-1:0]     pending_next;

    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign slow_ready = !full;
    assign push       = slow_valid && !full;
    assign pop        = !alu_valid && !empty;
    assign fifo_count = count;
    assign rs1_busy   = pending[rs1];
    assign rs2_busy   = pending[rs2];

    // Pick this cycle's write: ALU has priority, otherwise the FIFO head.
    always_comb begin
        sel_vld_p0  = 1'b0;
        sel_rd_p0   = '0;
        sel_data_p0 = '0;
        if (alu_valid) begin
            sel_vld_p0  = 1'b1;
            sel_rd_p0   = alu_rd;
            sel_data_p0 = alu_data;
        end else if (!empty) begin
            sel_vld_p0  = 1'b1;
            sel_rd_p0   = fifo_rd[rd_ptr];
            sel_data_p0 = fifo_data[rd_ptr];
        end
    end

    // FIFO storage is data only; validity comes from the count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= slow_rd;
            fifo_data[wr_ptr] <= slow_data;
        end
    end

    // FIFO pointers wrap naturally (power-of-two depth); count is one bit wider.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered write port; x0 writes consume the slot but never assert RegWrite.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite <= 1'b0;
            RW       <= '0;
            busW     <= '0;
        end else begin
            RegWrite <= sel_vld_p0 && (sel_rd_p0 != '0);
            if (sel_vld_p0 && (sel_rd_p0 != '0)) begin
                RW   <= sel_rd_p0;
                busW <= sel_data_p0;
            end
        end
    end

    // Scoreboard update: retire the registered write, then a new issue wins.
    always_comb begin
        pending_next = pending;
        if (RegWrite) pending_next[RW] = 1'b0;
        if (issue_valid && (issue_rd != '0)) pending_next[issue_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    // Pending-destination bits.
    always_ff @(posedge clk) begin
        if (reset) pending <= '0;
        else       pending <= pending_next;
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a queue-based
// reference model of the write-selection, FIFO and scoreboard rules.
module tb_regfile_writeback;
    localparam int WIDTH = 32;
    localparam int RA    = 5;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             alu_valid, slow_valid, issue_valid;
    logic [RA-1:0]    alu_rd, slow_rd, issue_rd, rs1, rs2;
    logic [WIDTH-1:0] alu_data, slow_data;
    logic             slow_ready, rs1_busy, rs2_busy, RegWrite;
    logic [RA-1:0]    RW;
    logic [WIDTH-1:0] busW;
    logic [$clog2(DEPTH):0] fifo_count;

    regfile_writeback #(.WIDTH(WIDTH), .REGADDR_W(RA), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .slow_valid(slow_valid), .slow_ready(slow_ready),
        .slow_rd(slow_rd), .slow_data(slow_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .RW(RW), .RegWrite(RegWrite), .busW(busW), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model state.
    typedef struct { logic [RA-1:0] rd; logic [WIDTH-1:0] data; } wr_t;
    wr_t              q[$];
    bit               pend[32];
    bit               exp_we;
    logic [RA-1:0]    exp_rw;
    logic [WIDTH-1:0] exp_busw;
    bit               port_known;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic clear_in();
        reset = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
        slow_valid = 0; slow_rd = 0; slow_data = 0;
        issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic model_update();
        wr_t w;
        bit  sel, acc;
        if (reset) begin
            q.delete();
            foreach (pend[i]) pend[i] = 0;
            exp_we = 0; exp_rw = 0; exp_busw = 0; port_known = 1;
            return;
        end
        acc = slow_valid && (q.size() < DEPTH);
        sel = 0;
        if (alu_valid) begin
            sel = 1; w.rd = alu_rd; w.data = alu_data;
        end else if (q.size() > 0) begin
            sel = 1; w = q.pop_front();
        end
        if (acc) q.push_back('{rd: slow_rd, data: slow_data});
        if (exp_we) pend[exp_rw] = 0;
        if (issue_valid && issue_rd != 0) pend[issue_rd] = 1;
        exp_we = sel && (w.rd != 0);
        if (exp_we) begin
            exp_rw = w.rd; exp_busw = w.data; port_known = 1;
        end else if (sel) begin
            port_known = 0;
        end
    endtask

    // Inputs are set at the falling edge; one call covers one clock cycle.
    task automatic step();
        #1;
        chk("slow_ready", slow_ready, q.size() < DEPTH);
        chk("rs1_busy", rs1_busy, pend[rs1]);
        chk("rs2_busy", rs2_busy, pend[rs2]);
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("RegWrite", RegWrite, exp_we);
        chk("fifo_count", fifo_count, q.size());
        if (port_known) begin
            chk("RW", RW, exp_rw);
            chk("busW", busW, exp_busw);
        end
    endtask

    initial begin
        int idx;
        clear_in();
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        step();

        // Single ALU write, then idle.
        clear_in(); alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; step();
        clear_in(); step();
        chk("t1_rw", RW, 5);
        chk("t1_busw", busW, 32'hDEADBEEF);

        // Slow pushes with idle ALU.
        for (int i = 0; i < 4; i++) begin
            clear_in(); slow_valid = 1; slow_rd = RA'(6 + i); slow_data = 32'h10 + i; step();
        end
        clear_in(); step(); step();

        // ALU busy for 6 cycles while pushing 5 results; producer holds when not ready.
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            clear_in(); alu_valid = 1; alu_rd = RA'(20 + c); alu_data = 32'h200 + c;
            if (idx < 5) begin
                slow_valid = 1; slow_rd = RA'(10 + idx); slow_data = 32'h100 + idx;
            end
            if (slow_valid && q.size() < DEPTH) idx++;
            step();
        end
        chk("t2_full", slow_ready, 0);
        for (int c = 0; c < 10; c++) begin
            clear_in();
            if (idx < 5) begin
                slow_valid = 1; slow_rd = RA'(10 + idx); slow_data = 32'h100 + idx;
            end
            if (slow_valid && q.size() < DEPTH) idx++;
            step();
        end
        chk("t2_drained", fifo_count, 0);

        // ALU and FIFO head competing.
        clear_in(); alu_valid = 1; alu_rd = 1; alu_data = 1;
        slow_valid = 1; slow_rd = 4; slow_data = 32'hB; step();
        clear_in(); alu_valid = 1; alu_rd = 3; alu_data = 32'hA; step();
        clear_in(); step(); step();

        // x0 suppression on both paths.
        clear_in(); alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF; step();
        clear_in(); slow_valid = 1; slow_rd = 0; slow_data = 32'h55; step();
        clear_in(); step(); step();

        // Scoreboard set, retire, and set-wins-over-clear.
        clear_in(); issue_valid = 1; issue_rd = 7; step();
        clear_in(); rs1 = 7; slow_valid = 1; slow_rd = 7; slow_data = 32'h77; step();
        clear_in(); rs1 = 7; step();
        clear_in(); rs1 = 7; step();
        clear_in(); rs1 = 7; issue_valid = 1; issue_rd = 7; step();
        clear_in(); slow_valid = 1; slow_rd = 7; slow_data = 32'h78; rs1 = 7; step();
        clear_in(); rs1 = 7; step();
        clear_in(); rs1 = 7; issue_valid = 1; issue_rd = 7; step();
        clear_in(); rs1 = 7; step();
        chk("t5_busy_kept", rs1_busy, 1);

        // Mid-operation reset with buffered entries and pending bits.
        for (int i = 0; i < 3; i++) begin
            clear_in(); alu_valid = 1; alu_rd = 1; alu_data = i;
            slow_valid = 1; slow_rd = RA'(12 + i); slow_data = 32'h300 + i;
            issue_valid = (i < 2); issue_rd = (i == 0) ? 5'd2 : 5'd9;
            step();
        end
        clear_in(); reset = 1; alu_valid = 1; alu_rd = 3; alu_data = 32'h9; step();
        clear_in(); rs1 = 2; rs2 = 9; step();
        chk("t6_count", fifo_count, 0);
        chk("t6_busy", {rs1_busy, rs2_busy}, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            clear_in();
            reset       = ($urandom_range(99) == 0);
            alu_valid   = ($urandom_range(9) < 4);
            alu_rd      = ($urandom_range(7) == 0) ? 5'd0 : RA'($urandom);
            alu_data    = $urandom;
            slow_valid  = ($urandom_range(1) == 1);
            slow_rd     = ($urandom_range(7) == 0) ? 5'd0 : RA'($urandom);
            slow_data   = $urandom;
            issue_valid = ($urandom_range(9) < 3);
            issue_rd    = RA'($urandom);
            rs1         = RA'($urandom);
            rs2         = RA'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
